// File: rtl/paddle_pkg.sv
// Shared paddle definitions: speed width, direction/source codes,
// button FSM states, playfield bounds and the saturating speed adder.
package paddle_pkg;

  localparam int SPEED_W = 5;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam logic SRC_KNOB = 1'b0;
  localparam logic SRC_BTN  = 1'b1;

  localparam int LEFT = 8;
  localparam int MAXX = 600;

  typedef enum logic [1:0] {
    B_IDLE   = 2'd0,
    B_DELAY  = 2'd1,
    B_REPEAT = 2'd2
  } btn_state_t;

  // 6-bit sum so the step can never wrap past the ceiling.
  function automatic logic [SPEED_W-1:0] speed_add(
    input logic [SPEED_W-1:0] cur,
    input logic [SPEED_W-1:0] step,
    input logic [SPEED_W-1:0] max
  );
    logic [SPEED_W:0] sum;
    sum = {1'b0, cur} + {1'b0, step};
    if (sum > {1'b0, max}) begin
      return max;
    end
    return sum[SPEED_W-1:0];
  endfunction

endpackage

// File: rtl/paddle_autorepeat.sv
// Button auto-repeat FSM: one request on press, one after REPEAT_DELAY,
// then one every REPEAT_PERIOD while the same single button stays held.
// Ports: clock, reset (sync, high), enable, btn_left, btn_right -> req, req_right.
module paddle_autorepeat
  import paddle_pkg::*;
#(
  parameter int REPEAT_DELAY  = 250000,
  parameter int REPEAT_PERIOD = 100000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic btn_left,
  input  logic btn_right,
  output logic req,
  output logic req_right
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                           REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DELAY_END  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_END = CNT_W'(REPEAT_PERIOD - 1);

  btn_state_t state;
  btn_state_t state_nxt;
  logic dir;
  logic dir_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_end;
  logic press;

  // Both buttons or neither is treated as no press.
  assign press = btn_left ^ btn_right;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= B_IDLE;
      dir   <= DIR_LEFT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      dir   <= dir_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    cnt_nxt   = cnt;
    req       = 1'b0;
    req_right = dir;
    cnt_end   = (state == B_DELAY) ? DELAY_END : PERIOD_END;
    if (!enable) begin
      state_nxt = B_IDLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        B_IDLE: begin
          if (press) begin
            state_nxt = B_DELAY;
            dir_nxt   = btn_right;
            cnt_nxt   = '0;
            req       = 1'b1;
            req_right = btn_right;
          end
        end
        B_DELAY, B_REPEAT: begin
          // A swap drops to idle; the new button re-presses next cycle.
          if (!press || (btn_right != dir)) begin
            state_nxt = B_IDLE;
            cnt_nxt   = '0;
          end else if (cnt == cnt_end) begin
            state_nxt = B_REPEAT;
            cnt_nxt   = '0;
            req       = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = B_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/paddle_move_scheduler.sv
// Arbitrates rotary pulses and button auto-repeat onto one move strobe
// with speed acceleration (PADDLE_MOVE_ACCEL_EN; constant speed otherwise).
// Ports: clock, reset (sync, high), enable, rot_event, rot_right,
// btn_left, btn_right -> move_event, move_right, speed[4:0], move_src.
module paddle_move_scheduler
  import paddle_pkg::*;
#(
  parameter int REPEAT_DELAY  = 250000,
  parameter int REPEAT_PERIOD = 100000,
  parameter int ACCEL_WIN     = 500000,
  parameter int SPEED_MIN     = 2,
  parameter int SPEED_STEP    = 2,
  parameter int SPEED_MAX     = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               rot_event,
  input  logic               rot_right,
  input  logic               btn_left,
  input  logic               btn_right,
  output logic               move_event,
  output logic               move_right,
  output logic [SPEED_W-1:0] speed,
  output logic               move_src
);

  if (SPEED_MAX > 31 || SPEED_MIN > SPEED_MAX ||
      SPEED_STEP < 1 || ACCEL_WIN < 1) begin : g_cfg_bad
    $error("paddle_move_scheduler: bad speed/accel configuration");
  end

  localparam logic [SPEED_W-1:0] S_MIN = SPEED_W'(SPEED_MIN);

  logic req;
  logic req_right;
  logic pending;
  logic pend_right;
  logic pend_live;
  logic btn_avail;
  logic btn_dir;
  logic issue;
  logic issue_right;
  logic issue_src;
  logic pending_nxt;
  logic pend_right_nxt;
  logic [SPEED_W-1:0] speed_nxt;

  paddle_autorepeat #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_autorepeat (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .req       (req),
    .req_right (req_right)
  );

  // A held-back button move dies on release or direction change.
  assign pend_live = pending && (btn_left ^ btn_right) &&
                     (btn_right == pend_right);

  always_comb begin
    btn_avail      = pend_live | req;
    btn_dir        = pend_live ? pend_right : req_right;
    issue          = 1'b0;
    issue_right    = move_right;
    issue_src      = move_src;
    pending_nxt    = 1'b0;
    pend_right_nxt = pend_right;
    priority case (1'b1)
      rot_event: begin
        issue          = 1'b1;
        issue_right    = rot_right;
        issue_src      = SRC_KNOB;
        pending_nxt    = btn_avail;
        pend_right_nxt = btn_dir;
      end
      btn_avail: begin
        issue       = 1'b1;
        issue_right = btn_dir;
        issue_src   = SRC_BTN;
      end
      default: ;
    endcase
  end

`ifdef PADDLE_MOVE_ACCEL_EN
  localparam int GAP_W = $clog2(ACCEL_WIN + 1);
  localparam logic [GAP_W-1:0]   GAP_SAT = GAP_W'(ACCEL_WIN);
  localparam logic [SPEED_W-1:0] S_STEP  = SPEED_W'(SPEED_STEP);
  localparam logic [SPEED_W-1:0] S_MAX   = SPEED_W'(SPEED_MAX);

  logic [GAP_W-1:0] gap;
  logic last_ok;

  // last_ok separates "no previous move" from a genuine short gap.
  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      gap     <= '0;
      last_ok <= 1'b0;
    end else if (issue) begin
      gap     <= '0;
      last_ok <= 1'b1;
    end else if (gap != GAP_SAT) begin
      gap <= gap + 1'b1;
    end
  end

  assign speed_nxt = (last_ok && (issue_right == move_right) &&
                      (gap < GAP_SAT)) ?
                     speed_add(speed, S_STEP, S_MAX) : S_MIN;
`else
  assign speed_nxt = S_MIN;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      move_event <= 1'b0;
      move_right <= DIR_LEFT;
      speed      <= S_MIN;
      move_src   <= SRC_KNOB;
      pending    <= 1'b0;
      pend_right <= DIR_LEFT;
    end else if (!enable) begin
      move_event <= 1'b0;
      speed      <= S_MIN;
      pending    <= 1'b0;
    end else begin
      move_event <= issue;
      pending    <= pending_nxt;
      pend_right <= pend_right_nxt;
      if (issue) begin
        move_right <= issue_right;
        speed      <= speed_nxt;
        move_src   <= issue_src;
      end
    end
  end

endmodule

// File: tb/tb_paddle_move_scheduler.sv
// Scoreboard bench for paddle_move_scheduler with short timing
// parameters; expected moves are queued as stimulus is driven.
`timescale 1ns/1ps
module tb_paddle_move_scheduler;

  logic clock = 1'b0;
  logic reset;
  logic enable;
  logic rot_event;
  logic rot_right;
  logic btn_left;
  logic btn_right;
  logic move_event;
  logic move_right;
  logic [4:0] speed;
  logic move_src;

  always #5 clock = ~clock;

  paddle_move_scheduler #(
    .REPEAT_DELAY  (8),
    .REPEAT_PERIOD (4),
    .ACCEL_WIN     (16),
    .SPEED_MIN     (2),
    .SPEED_STEP    (2),
    .SPEED_MAX     (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .rot_event  (rot_event),
    .rot_right  (rot_right),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .move_event (move_event),
    .move_right (move_right),
    .speed      (speed),
    .move_src   (move_src)
  );

  typedef struct {
    int cyc;
    int right;
    int spd;
    int src;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  int strobes = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d",
               tag, cyc, got, exp);
    end
  endtask

  function automatic int acc(input int s);
    int r;
    r = s;
`ifndef PADDLE_MOVE_ACCEL_EN
    r = 2;
`endif
    return r;
  endfunction

  task automatic expect_move(input int c, input int r,
                             input int s, input int src);
    exp_t e;
    e.cyc   = c;
    e.right = r;
    e.spd   = s;
    e.src   = src;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clock);
    #1;
    cyc++;
    if (move_event) begin
      strobes++;
      if (sb.size() == 0) begin
        check("spurious_move", int'(move_event), 0);
      end else begin
        e = sb.pop_front();
        check("move_cycle", cyc, e.cyc);
        check("move_right", int'(move_right), e.right);
        check("speed", int'(speed), e.spd);
        check("move_src", int'(move_src), e.src);
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      check("missing_move", int'(move_event), 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_event"}, int'(move_event), 0);
    check({tag, "_right"}, int'(move_right), 0);
    check({tag, "_speed"}, int'(speed), 2);
    check({tag, "_src"}, int'(move_src), 0);
  endtask

  initial begin
    int t0;
    int s0;
    reset = 1'b1;
    enable = 1'b0;
    rot_event = 1'b0;
    rot_right = 1'b0;
    btn_left = 1'b0;
    btn_right = 1'b0;
    idle(3);
    check_reset_vals("rst");
    reset = 1'b0;
    enable = 1'b1;

    // rotary move, one-cycle latency
    t0 = cyc;
    idle(10);
    rot_event = 1'b1;
    rot_right = 1'b1;
    expect_move(t0 + 11, 1, 2, 0);
    tick();
    rot_event = 1'b0;
    idle(20);

    // left button auto-repeat
    t0 = cyc;
    btn_left = 1'b1;
    expect_move(t0 + 1,  0, 2, 1);
    expect_move(t0 + 9,  0, acc(4), 1);
    expect_move(t0 + 13, 0, acc(6), 1);
    expect_move(t0 + 17, 0, acc(8), 1);
    expect_move(t0 + 21, 0, acc(10), 1);
    expect_move(t0 + 25, 0, acc(12), 1);
    expect_move(t0 + 29, 0, acc(14), 1);
    idle(30);
    btn_left = 1'b0;
    idle(20);

    // acceleration saturation
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      rot_event = 1'b1;
      rot_right = 1'b1;
      expect_move(t0 + 3 * i + 1, 1,
                  acc((2 + 2 * i > 16) ? 16 : 2 + 2 * i), 0);
      tick();
      rot_event = 1'b0;
      idle(2);
    end
    idle(17);
    rot_event = 1'b1;
    expect_move(t0 + 48, 1, 2, 0);
    tick();
    rot_event = 1'b0;
    idle(20);

    // collision: rotary first, button next cycle
    t0 = cyc;
    btn_left = 1'b1;
    rot_event = 1'b1;
    rot_right = 1'b0;
    expect_move(t0 + 1, 0, 2, 0);
    expect_move(t0 + 2, 0, acc(4), 1);
    tick();
    rot_event = 1'b0;
    tick();
    btn_left = 1'b0;
    idle(20);

    // collision with a second rotary pulse
    t0 = cyc;
    btn_left = 1'b1;
    rot_event = 1'b1;
    rot_right = 1'b0;
    expect_move(t0 + 1, 0, 2, 0);
    expect_move(t0 + 2, 0, acc(4), 0);
    expect_move(t0 + 3, 0, acc(6), 1);
    tick();
    tick();
    rot_event = 1'b0;
    tick();
    btn_left = 1'b0;
    idle(20);

    // both buttons held
    s0 = strobes;
    btn_left = 1'b1;
    btn_right = 1'b1;
    idle(30);
    btn_left = 1'b0;
    btn_right = 1'b0;
    idle(3);
    check("both_btn_strobes", strobes - s0, 0);
    idle(20);

    // enable drop during repeat
    t0 = cyc;
    btn_right = 1'b1;
    expect_move(t0 + 1,  1, 2, 1);
    expect_move(t0 + 9,  1, acc(4), 1);
    expect_move(t0 + 13, 1, acc(6), 1);
    idle(14);
    enable = 1'b0;
    s0 = strobes;
    repeat (10) begin
      tick();
      check("speed_disabled", int'(speed), 2);
    end
    check("disabled_strobes", strobes - s0, 0);
    enable = 1'b1;
    expect_move(t0 + 25, 1, 2, 1);
    tick();
    btn_right = 1'b0;
    idle(20);

    // reset during repeat with a pending button move
    t0 = cyc;
    btn_right = 1'b1;
    expect_move(t0 + 1,  1, 2, 1);
    expect_move(t0 + 9,  1, acc(4), 1);
    expect_move(t0 + 13, 1, acc(6), 0);
    idle(12);
    rot_event = 1'b1;
    rot_right = 1'b1;
    tick();
    rot_event = 1'b0;
    reset = 1'b1;
    btn_right = 1'b0;
    tick();
    check_reset_vals("midrst");
    reset = 1'b0;
    s0 = strobes;
    idle(10);
    check("post_reset_strobes", strobes - s0, 0);

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
